// File: rtl/regfile_mp_pkg.sv
// Shared defaults and flattened-bus helpers for the multi-port register file.
package regfile_mp_pkg;

    localparam int RF_WIDTH_DEF  = 32;
    localparam int RF_NREGS_DEF  = 32;
    localparam int RF_NREAD_DEF  = 2;
    localparam int RF_NWRITE_DEF = 2;

    // Low bit of field idx in a bus of fields that are w bits wide.
    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a registered population count.
module regfile_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int NREGS    = RF_NREGS_DEF,
    parameter int NWRITE   = RF_NWRITE_DEF,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NWRITE-1:0]    regwrite,
    input  logic [NWRITE*AW-1:0] wreg,
    input  logic                 claim,
    input  logic [AW-1:0]        claim_reg,
    input  logic                 flush,
    output logic [NREGS-1:0]     busy,
    output logic [AW:0]          busy_cnt
);

    logic [NREGS-1:0] busy_d, busy_q;
    logic [AW:0]      busy_cnt_d, busy_cnt_q;

    // Writeback retires first, so a claim on the same register re-marks it pending.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            for (int j = 0; j < NWRITE; j++) begin
                if (regwrite[j]) begin
                    busy_d[wreg[slice_lo(j, AW) +: AW]] = 1'b0;
                end
            end
            if (claim && !(ZERO_REG != 0 && claim_reg == '0)) begin
                busy_d[claim_reg] = 1'b1;
            end
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    always_comb begin
        busy_cnt_d = '0;
        for (int r = 0; r < NREGS; r++) begin
            busy_cnt_d = busy_cnt_d + {{AW{1'b0}}, busy_d[r]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy     = busy_q;
    assign busy_cnt = busy_cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with same-cycle write bypass and a pending-write scoreboard.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH_DEF,
    parameter int NREGS    = RF_NREGS_DEF,
    parameter int NREAD    = RF_NREAD_DEF,
    parameter int NWRITE   = RF_NWRITE_DEF,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREAD*AW-1:0]     rreg,
    output logic [NREAD*WIDTH-1:0]  rdata,
    output logic [NREAD-1:0]        rbusy,
    input  logic [NWRITE-1:0]       regwrite,
    input  logic [NWRITE*AW-1:0]    wreg,
    input  logic [NWRITE*WIDTH-1:0] wdata,
    input  logic                    claim,
    input  logic [AW-1:0]           claim_reg,
    input  logic                    flush,
    output logic [AW:0]             busy_cnt
);

    logic [WIDTH-1:0] mem_q [NREGS];
    logic [WIDTH-1:0] mem_d [NREGS];
    logic [NREGS-1:0] busy;

    // Ascending port order: the highest enabled port to a register wins.
    always_comb begin
        mem_d = mem_q;
        for (int j = 0; j < NWRITE; j++) begin
            if (regwrite[j] && !(ZERO_REG != 0 && wreg[slice_lo(j, AW) +: AW] == '0)) begin
                mem_d[wreg[slice_lo(j, AW) +: AW]] = wdata[slice_lo(j, WIDTH) +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .NWRITE   (NWRITE),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .regwrite  (regwrite),
        .wreg      (wreg),
        .claim     (claim),
        .claim_reg (claim_reg),
        .flush     (flush),
        .busy      (busy),
        .busy_cnt  (busy_cnt)
    );

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0]    ra;
        logic [WIDTH-1:0] rd;
        logic             hit;

        assign ra = rreg[i*AW +: AW];

        always_comb begin
            rd  = mem_q[ra];
            hit = 1'b0;
            for (int j = 0; j < NWRITE; j++) begin
                if (BYPASS != 0 && regwrite[j] && wreg[slice_lo(j, AW) +: AW] == ra) begin
                    rd  = wdata[slice_lo(j, WIDTH) +: WIDTH];
                    hit = 1'b1;
                end
            end
            if (ZERO_REG != 0 && ra == '0) begin
                rd = '0;
            end
        end

        assign rdata[i*WIDTH +: WIDTH] = rd;
        // A writeback in flight releases the consumer unless a new producer claims it this cycle.
        assign rbusy[i] = busy[ra] & ~(hit & ~(claim & (claim_reg == ra)));
    end

endmodule
